// File: rtl/decrypt128.sv
// rtl/decrypt128.sv - AES-128 iterative decryption core, one inverse round per clock
package aes_inv_pkg;

  // multiply by x in GF(2^8) modulo 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // multiplicative inverse as x^254 (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = gmul(x, x);
    r = p;
    for (int k = 0; k < 6; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // forward S-box, needed by the key schedule
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // inverse S-box: undo the affine map, then invert
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  // InvShiftRows followed by InvSubBytes; byte k = row (k%4), column (k/4)
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c - r + 4) % 4);
        o[127 - 8 * (r + 4 * c) -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// Combinational AES-128 key schedule producing rk0..rk10
module key_expand128 #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic [127:0]          key,
  output logic [nr:0][127:0]    round_keys
);
  import aes_inv_pkg::*;

  logic [31:0] w [0:4*(nr+1)-1];

  // expand key words, then pack four words per round key
  always_comb begin
    logic [31:0] temp;
    logic [7:0]  rcon;
    temp = 32'h0;
    rcon = 8'h01;
    for (int k = 0; k < nk; k++) begin
      w[k] = key[127 - 32 * k -: 32];
    end
    for (int k = nk; k < 4 * (nr + 1); k++) begin
      temp = w[k - 1];
      if (k % nk == 0) begin
        temp = {sbox(temp[23:16]), sbox(temp[15:8]), sbox(temp[7:0]), sbox(temp[31:24])}
               ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[k] = w[k - nk] ^ temp;
    end
    for (int n = 0; n <= nr; n++) begin
      round_keys[n] = {w[4 * n], w[4 * n + 1], w[4 * n + 2], w[4 * n + 3]};
    end
  end
endmodule

// state XOR round key
module addRoundKey (
  input  logic [127:0] state,
  input  logic [127:0] rk,
  output logic [127:0] result
);
  assign result = state ^ rk;
endmodule

// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
module decryptRound (
  input  logic [127:0] state,
  input  logic [127:0] rk,
  output logic [127:0] result
);
  import aes_inv_pkg::*;
  assign result = inv_mix_columns(inv_shift_sub(state) ^ rk);
endmodule

// InvShiftRows -> InvSubBytes -> AddRoundKey, no InvMixColumns
module decryptLastRound (
  input  logic [127:0] state,
  input  logic [127:0] rk,
  output logic [127:0] result
);
  import aes_inv_pkg::*;
  assign result = inv_shift_sub(state) ^ rk;
endmodule

module decrypt128 #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] Message,
  input  logic [127:0] Key,
  output logic [127:0] decipher
);
  localparam logic [4:0] LOAD_END  = 5'(nr);
  localparam logic [4:0] FIRST_ARK = 5'(nr + 1);
  localparam logic [4:0] ROUND_END = 5'(2 * nr);
  localparam logic [4:0] LAST_RND  = 5'(2 * nr + 1);

  logic [4:0]             i;
  logic [nr:0][127:0]     round_keys;
  logic [3:0]             rk_idx;
  logic [127:0]           ark_out;
  logic [127:0]           round_out;
  logic [127:0]           last_out;

  key_expand128 #(.nk(nk), .nr(nr)) u_key (
    .key        (Key),
    .round_keys (round_keys)
  );

  // rounds i=12..20 consume rk9 down to rk1; other phases park on rk0
  always_comb begin
    rk_idx = 4'd0;
    if (i > FIRST_ARK && i <= ROUND_END) rk_idx = 4'(LAST_RND - i);
  end

  addRoundKey u_ark (
    .state  (Message),
    .rk     (round_keys[nr]),
    .result (ark_out)
  );

  decryptRound u_round (
    .state  (decipher),
    .rk     (round_keys[rk_idx]),
    .result (round_out)
  );

  decryptLastRound u_last (
    .state  (decipher),
    .rk     (round_keys[0]),
    .result (last_out)
  );

  // sequencer: load phase while the key schedule settles, then one round per edge, then hold
  always_ff @(posedge clk) begin
    if (reset) begin
      i        <= 5'd0;
      decipher <= '0;
    end else if (i <= LOAD_END) begin
      decipher <= Message;
      i        <= i + 5'd1;
    end else if (i == FIRST_ARK) begin
      decipher <= ark_out;
      i        <= i + 5'd1;
    end else if (i <= ROUND_END) begin
      decipher <= round_out;
      i        <= i + 5'd1;
    end else if (i == LAST_RND) begin
      decipher <= last_out;
      i        <= i + 5'd1;
    end
  end
endmodule

// File: tb/tb_decrypt128.sv
// tb/tb_decrypt128.sv - randomized self-checking bench for decrypt128 against a byte-level AES model
module tb_decrypt128;

  logic         clk;
  logic         reset;
  logic [127:0] Message;
  logic [127:0] Key;
  logic [127:0] decipher;

  int tests;
  int failed;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  decrypt128 dut (
    .clk      (clk),
    .reset    (reset),
    .Message  (Message),
    .Key      (Key),
    .decipher (decipher)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box tables from the generator-3 walk of GF(2^8)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int k = 0; k < 256; k++) isb[sb[k]] = 8'(k);
  endtask

  function automatic logic [127:0] model_rk(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int k = 0; k < 4; k++) w[k] = key[127 - 32 * k -: 32];
    for (int k = 4; k < 44; k++) begin
      t = w[k - 1];
      if (k % 4 == 0) begin
        t = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
        rc = xt(rc);
      end
      w[k] = w[k - 4] ^ t;
    end
    return {w[4 * n], w[4 * n + 1], w[4 * n + 2], w[4 * n + 3]};
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk;
    logic [127:0] o;
    rk = model_rk(key, 10);
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8 * k -: 8] ^ rk[127 - 8 * k -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4 * c] = s[r + 4 * ((c - r + 4) % 4)];
      rk = model_rk(key, rnd);
      for (int k = 0; k < 16; k++) s[k] = isb[t[k]] ^ rk[127 - 8 * k -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          t[4*c]   = mul(s[4*c], 8'h0e) ^ mul(s[4*c+1], 8'h0b) ^ mul(s[4*c+2], 8'h0d) ^ mul(s[4*c+3], 8'h09);
          t[4*c+1] = mul(s[4*c], 8'h09) ^ mul(s[4*c+1], 8'h0e) ^ mul(s[4*c+2], 8'h0b) ^ mul(s[4*c+3], 8'h0d);
          t[4*c+2] = mul(s[4*c], 8'h0d) ^ mul(s[4*c+1], 8'h09) ^ mul(s[4*c+2], 8'h0e) ^ mul(s[4*c+3], 8'h0b);
          t[4*c+3] = mul(s[4*c], 8'h0b) ^ mul(s[4*c+1], 8'h0d) ^ mul(s[4*c+2], 8'h09) ^ mul(s[4*c+3], 8'h0e);
        end
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = s[k];
    return o;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    check("reset_zero", decipher, 128'h0);
    reset = 1'b0;
  endtask

  // full run from reset: checks edge 1, edge 12 and edge 22
  task automatic run_vector(input string tag, input logic [127:0] k, input logic [127:0] m,
                            input logic [127:0] pt);
    Key     = k;
    Message = m;
    do_reset();
    step(1);
    check({tag, "_edge1"}, decipher, m);
    step(11);
    check({tag, "_edge12"}, decipher, m ^ model_rk(k, 10));
    step(10);
    check({tag, "_edge22"}, decipher, pt);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] rk_new, rm_new, pt_new;
    tests   = 0;
    failed  = 0;
    clk     = 1'b0;
    reset   = 1'b1;
    Key     = '0;
    Message = '0;
    build_sbox();

    // the model itself against known FIPS answers
    check("model_c1", model_decrypt(C1_KEY, C1_CT), C1_PT);
    check("model_rk10_c1", model_rk(C1_KEY, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // FIPS-197 C.1, then hold until edge 40
    run_vector("c1", C1_KEY, C1_CT, C1_PT);
    step(18);
    check("c1_edge40_hold", decipher, C1_PT);

    // FIPS-197 appendix B
    run_vector("appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);

    // zero key
    run_vector("zkey", 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0);

    // reset mid-operation at edge 15, plaintext exactly 22 edges after release
    Key     = C1_KEY;
    Message = C1_CT;
    do_reset();
    step(14);
    reset = 1'b1;
    step(1);
    check("midop_reset_zero", decipher, 128'h0);
    reset = 1'b0;
    step(1);
    check("midop_edge1", decipher, C1_CT);
    step(20);
    check("midop_not_early", {127'b0, decipher == C1_PT}, 128'h0);
    step(1);
    check("midop_edge22", decipher, C1_PT);

    // inputs change after done: output holds, then new inputs decrypt after reset
    rk_new  = {$urandom, $urandom, $urandom, $urandom};
    rm_new  = {$urandom, $urandom, $urandom, $urandom};
    Key     = rk_new;
    Message = rm_new;
    step(5);
    check("postdone_hold", decipher, C1_PT);
    pt_new = model_decrypt(rk_new, rm_new);
    run_vector("postdone_new", rk_new, rm_new, pt_new);

    // randomized keys and blocks against the model
    for (int n = 0; n < 6; n++) begin
      rk_new = {$urandom, $urandom, $urandom, $urandom};
      rm_new = {$urandom, $urandom, $urandom, $urandom};
      run_vector($sformatf("rand%0d", n), rk_new, rm_new, model_decrypt(rk_new, rm_new));
    end

    // reset held several cycles stays at zero
    reset = 1'b1;
    step(3);
    check("reset_held", decipher, 128'h0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/decrypt128.md
# decrypt128

AES-128 (FIPS-197) iterative decryption core. It expands a 128-bit cipher key into 11 round keys and applies the inverse cipher to one 128-bit ciphertext block, one round per clock. The result is presented on `decipher`. It is the top of the decrypt path. It instantiates a key expander, an `addRoundKey` stage, one shared inverse-round datapath and a `decryptLastRound` stage.

## Interface
Parameters:
- `nk`, 4: key length in 32-bit words (fixed at 4 for AES-128).
- `nr`, 10: number of rounds (fixed at 10).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; clears the round counter and `decipher`.
- `Message`, in, 128: ciphertext block; bit 127 is the MSB of byte 0; bytes are column-major (bytes 0–3 form column 0).
- `Key`, in, 128: cipher key, with the same byte ordering as `Message`.
- `decipher`, out, 128: registered state; holds the plaintext once the operation completes.

## Operation
- Key expansion is purely combinational from `Key`.
  - Standard AES-128 schedule: RotWord, SubWord and Rcon 01,02,04,08,10,20,40,80,1B,36.
  - Produces 44 words, forming round keys rk0 (= `Key`) through rk10.
- `addRoundKey(state, rk)` = state XOR rk (combinational).
- Inverse round (combinational): InvShiftRows → InvSubBytes → AddRoundKey(rk) → InvMixColumns.
- `decryptLastRound` (combinational): InvShiftRows → InvSubBytes → AddRoundKey(rk0), with no InvMixColumns.
- A 5-bit counter `i` sequences the core. On each rising edge with `reset`=0, by value of `i`:
  - `i` = 0..10 (load phase): `decipher` ← `Message`; `i` ← `i`+1.
  - `i` = 11: `decipher` ← `Message` XOR rk10; `i` ← 12.
  - `i` = 12..20: `decipher` ← InvRound(`decipher`, rk(21−`i`)); `i` ← `i`+1. This uses rk9 down to rk1.
  - `i` = 21: `decipher` ← decryptLastRound(`decipher`, rk0); `i` ← 22.
  - `i` = 22 (done): hold. Neither `i` nor `decipher` changes until `reset`.
- The counter never wraps. A new operation requires asserting `reset`.
- `Key` must be stable from reset release through `i` = 22.
- `Message` must be stable through the edge at `i` = 11. After that it is ignored.
- Input changes after done have no effect on `decipher`.
- The S-box is the inverse AES S-box.
- InvMixColumns uses the GF(2^8) multipliers 09, 0B, 0D, 0E with reduction polynomial 0x11B.

## Timing
- Reset: on an edge with `reset`=1, `i` ← 0 and `decipher` ← 0. `reset` has priority over all other actions.
- Power-up value of `decipher` is 0 and of `i` is 0. The core starts without reset when these initial values are honoured.
- First edge after reset: `decipher` = `Message` (ciphertext).
- 22nd rising edge after reset release: `decipher` = plaintext. The value is valid from then until the next reset.
- No valid/done strobe exists. Consumers count 22 cycles.
- Reset mid-operation (any `i`): the operation is discarded and restarts from `i` = 0 on the next edge. Plaintext appears 22 edges after the new release.
- Reset held for several cycles: `decipher` stays 0 and `i` stays 0.
- Critical path: one inverse S-box plus InvMixColumns plus XOR per cycle. The key-expansion path settles during the 11-cycle load phase.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: `Key`=000102030405060708090a0b0c0d0e0f, `Message`=69c4e0d86a7b0430d8cdb78070b4c55a, reset 1 cycle.
  - Response: `decipher`=0 during reset; equals `Message` after edge 1; equals 00112233445566778899aabbccddeeff after edge 22; unchanged at edge 40.
- FIPS-197 Appendix B vector:
  - Stimulus: `Key`=2b7e151628aed2a6abf7158809cf4f3c, `Message`=3925841d02dc09fbdc118597196a0b32.
  - Response: `decipher`=3243f6a8885a308d313198a2e0370734 at edge 22.
- Zero key:
  - Stimulus: `Key`=0, `Message`=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Response: `decipher`=0 at edge 22. Also check intermediate state after edge 12 equals `Message` XOR rk10.
- Reset mid-op:
  - Stimulus: run the C.1 vector, assert `reset` at edge 15 for 1 cycle, then release.
  - Response: `decipher`=0 at the reset edge; correct plaintext exactly 22 edges after release, not before.
- Post-done input change:
  - Stimulus: after edge 22, change `Message` and `Key` to random values.
  - Response: `decipher` holds the plaintext. After a reset it decrypts the new inputs correctly.
